// File: rtl/if_pipe_ctrl.sv
// rtl/if_pipe_ctrl.sv - fetch-stage and IF/ID, ID/EX sequencing controller
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_mem_read, ex_rt       load in EX and its destination register
//   id_rs, id_rt, id_uses_rt source operands of the instruction in ID
//   md_start                 mult/div issuing from ID this cycle
//   br_taken                 branch resolved taken this cycle
//   exc_req, exc_pc          exception request and faulting PC
//   hold_pc, hold_if         freeze PC / IF-ID registers
//   flush_id, flush_ex       squash IF-ID / bubble ID-EX at next edge
//   except                   fetch mux selects the exception vector
//   epc                      captured exception PC
//   md_busy                  mult/div unit occupied
module if_pipe_ctrl #(
    parameter int MD_LAT  = 32,
    parameter int EXC_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        md_start,
    input  logic        br_taken,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    output logic        hold_pc,
    output logic        hold_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        except,
    output logic [31:0] epc,
    output logic        md_busy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        EXC     = 2'd2
    } state_t;

    // Counters are loaded with "remaining cycles minus one" so the exit
    // happens on the edge where they read zero.
    localparam logic [7:0] MD_INIT  = 8'(MD_LAT - 2);
    localparam logic [3:0] EXC_INIT = 4'(EXC_CYC - 2);

    state_t      state, state_nxt;
    logic [7:0]  md_cnt, md_cnt_nxt;
    logic [3:0]  exc_cnt, exc_cnt_nxt;
    logic        epc_load;
    logic        lu;

    assign lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        exc_cnt_nxt = exc_cnt;
        epc_load    = 1'b0;
        hold_pc     = 1'b0;
        hold_if     = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        except      = 1'b0;
        md_busy     = 1'b0;

        if (!rst) begin
            case (state)
                RUN: begin
                    if (exc_req) begin
                        except   = 1'b1;
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                        epc_load = 1'b1;
                        if (EXC_CYC > 1) begin
                            state_nxt   = EXC;
                            exc_cnt_nxt = EXC_INIT;
                        end
                    end else if (lu) begin
                        // ID instruction is re-presented next cycle, so any
                        // md_start/br_taken it carries is seen again then.
                        hold_pc  = 1'b1;
                        hold_if  = 1'b1;
                        flush_ex = 1'b1;
                    end else if (md_start) begin
                        if (MD_LAT > 1) begin
                            state_nxt  = MD_WAIT;
                            md_cnt_nxt = MD_INIT;
                        end
                    end else if (br_taken) begin
                        flush_id = 1'b1;
                    end
                end

                MD_WAIT: begin
                    if (exc_req) begin
                        // Abort the mult/div; busy drops in this cycle.
                        except     = 1'b1;
                        flush_id   = 1'b1;
                        flush_ex   = 1'b1;
                        epc_load   = 1'b1;
                        md_cnt_nxt = 8'd0;
                        if (EXC_CYC > 1) begin
                            state_nxt   = EXC;
                            exc_cnt_nxt = EXC_INIT;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else begin
                        hold_pc  = 1'b1;
                        hold_if  = 1'b1;
                        flush_ex = 1'b1;
                        md_busy  = 1'b1;
                        if (md_cnt == 8'd0) begin
                            state_nxt = RUN;
                        end else begin
                            md_cnt_nxt = md_cnt - 8'd1;
                        end
                    end
                end

                EXC: begin
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    if (exc_cnt == 4'd0) begin
                        state_nxt = RUN;
                    end else begin
                        exc_cnt_nxt = exc_cnt - 4'd1;
                    end
                end

                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            md_cnt  <= 8'd0;
            exc_cnt <= 4'd0;
            epc     <= 32'd0;
        end else begin
            state   <= state_nxt;
            md_cnt  <= md_cnt_nxt;
            exc_cnt <= exc_cnt_nxt;
            if (epc_load) begin
                epc <= exc_pc;
            end
        end
    end

endmodule

// File: tb/tb_if_pipe_ctrl.sv
// tb/tb_if_pipe_ctrl.sv - directed self-checking bench for if_pipe_ctrl
module tb_if_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_read;
    logic [4:0]  ex_rt, id_rs, id_rt;
    logic        id_uses_rt;
    logic        md_start4, md_start1, md_start8;
    logic        br_taken;
    logic        exc_req;
    logic [31:0] exc_pc;

    // Output order: {hold_pc, hold_if, flush_id, flush_ex, except, md_busy}
    logic [5:0]  o4, o1, o8;
    logic [31:0] epc4, epc1, epc8;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    if_pipe_ctrl #(.MD_LAT(4), .EXC_CYC(2)) dut4 (
        .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .md_start(md_start4), .br_taken(br_taken), .exc_req(exc_req),
        .exc_pc(exc_pc), .hold_pc(o4[5]), .hold_if(o4[4]),
        .flush_id(o4[3]), .flush_ex(o4[2]), .except(o4[1]),
        .epc(epc4), .md_busy(o4[0])
    );

    if_pipe_ctrl #(.MD_LAT(1), .EXC_CYC(2)) dut1 (
        .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .md_start(md_start1), .br_taken(br_taken), .exc_req(exc_req),
        .exc_pc(exc_pc), .hold_pc(o1[5]), .hold_if(o1[4]),
        .flush_id(o1[3]), .flush_ex(o1[2]), .except(o1[1]),
        .epc(epc1), .md_busy(o1[0])
    );

    if_pipe_ctrl #(.MD_LAT(8), .EXC_CYC(2)) dut8 (
        .clk(clk), .rst(rst), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .md_start(md_start8), .br_taken(br_taken), .exc_req(exc_req),
        .exc_pc(exc_pc), .hold_pc(o8[5]), .hold_if(o8[4]),
        .flush_id(o8[3]), .flush_ex(o8[2]), .except(o8[1]),
        .epc(epc8), .md_busy(o8[0])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        rst = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rt = 1'b0; md_start4 = 1'b0; md_start1 = 1'b0; md_start8 = 1'b0;
        br_taken = 1'b0; exc_req = 1'b0; exc_pc = 32'd0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] NONE  = 6'b000000;
    localparam logic [5:0] LU    = 6'b110100;
    localparam logic [5:0] MDW   = 6'b110101;
    localparam logic [5:0] BR    = 6'b001000;
    localparam logic [5:0] EXQ   = 6'b001110;
    localparam logic [5:0] EXW   = 6'b001100;

    initial begin
        // Reset with competing requests
        idle();
        rst = 1'b1; exc_req = 1'b1; exc_pc = 32'h1234; md_start4 = 1'b1;
        md_start1 = 1'b1; md_start8 = 1'b1;
        @(negedge clk); chk("rst_out0", 32'(o4), 32'(NONE));
        next();
        @(negedge clk); chk("rst_out1", 32'(o4), 32'(NONE));
        chk("rst_epc", epc4, 32'h0);
        chk("rst_md8", 32'(o8), 32'(NONE));
        next();
        idle();
        @(negedge clk); chk("post_rst_out", 32'(o4), 32'(NONE));
        chk("post_rst_epc", epc4, 32'h0);

        // Load-use
        next();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        @(negedge clk); chk("lu_rs", 32'(o4), 32'(LU));
        next(); idle();
        @(negedge clk); chk("lu_clear", 32'(o4), 32'(NONE));
        next();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        @(negedge clk); chk("lu_r0", 32'(o4), 32'(NONE));
        next(); idle();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        @(negedge clk); chk("lu_rt_unused", 32'(o4), 32'(NONE));
        next();
        id_uses_rt = 1'b1;
        @(negedge clk); chk("lu_rt_used", 32'(o4), 32'(LU));
        next(); idle();

        // Mult/div MD_LAT=4 and MD_LAT=1
        md_start4 = 1'b1; md_start1 = 1'b1;
        @(negedge clk); chk("md4_issue", 32'(o4), 32'(NONE));
        chk("md1_issue", 32'(o1), 32'(NONE));
        next(); idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk($sformatf("md4_wait%0d", i), 32'(o4), 32'(MDW));
            chk($sformatf("md1_wait%0d", i), 32'(o1), 32'(NONE));
            next();
        end
        @(negedge clk); chk("md4_done", 32'(o4), 32'(NONE));
        next();

        // lu beats md_start: stall only, no MD_WAIT afterwards
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; md_start4 = 1'b1;
        @(negedge clk); chk("lu_over_md", 32'(o4), 32'(LU));
        next(); idle();
        @(negedge clk); chk("lu_over_md_after", 32'(o4), 32'(NONE));
        next();

        // Branch
        br_taken = 1'b1;
        @(negedge clk); chk("br_alone", 32'(o4), 32'(BR));
        next(); idle();
        @(negedge clk); chk("br_after", 32'(o4), 32'(NONE));
        next();
        br_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        @(negedge clk); chk("br_with_lu", 32'(o4), 32'(LU));
        next(); idle();

        // Exception, EXC_CYC=2, nested request masked
        exc_req = 1'b1; exc_pc = 32'h0000_0040; br_taken = 1'b1;
        @(negedge clk); chk("exc_entry", 32'(o4), 32'(EXQ));
        next();
        exc_req = 1'b1; exc_pc = 32'h0000_0044; br_taken = 1'b0;
        @(negedge clk); chk("exc_window", 32'(o4), 32'(EXW));
        chk("exc_epc", epc4, 32'h0000_0040);
        next(); idle();
        @(negedge clk); chk("exc_done", 32'(o4), 32'(NONE));
        chk("exc_epc_kept", epc4, 32'h0000_0040);
        next();

        // Abort MD_WAIT with MD_LAT=8
        md_start8 = 1'b1;
        @(negedge clk); chk("md8_issue", 32'(o8), 32'(NONE));
        next(); idle();
        @(negedge clk); chk("md8_wait1", 32'(o8), 32'(MDW));
        next();
        exc_req = 1'b1; exc_pc = 32'h0000_0080;
        @(negedge clk); chk("md8_abort", 32'(o8), 32'(EXQ));
        next(); idle();
        @(negedge clk); chk("md8_exc_window", 32'(o8), 32'(EXW));
        chk("md8_epc", epc8, 32'h0000_0080);
        next();
        @(negedge clk); chk("md8_after0", 32'(o8), 32'(NONE));
        next();
        @(negedge clk); chk("md8_after1", 32'(o8), 32'(NONE));
        next();

        // Reset in the middle of a mult/div stall
        md_start4 = 1'b1;
        @(negedge clk); chk("rst_mid_issue", 32'(o4), 32'(NONE));
        next(); idle();
        rst = 1'b1;
        @(negedge clk); chk("rst_mid_forced", 32'(o4), 32'(NONE));
        next(); idle();
        @(negedge clk); chk("rst_mid_run", 32'(o4), 32'(NONE));
        chk("rst_mid_epc", epc4, 32'h0);
        next();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
